// File: rtl/sap_pkg.sv
// Shared types for the SAP OBI-to-reg bridge: FSM states, bus bundles
// and the error read-data pattern.
package sap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } bridge_state_e;

    localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    // Read data returned to the host for a completed reg access.
    // Writes return zero; any error returns the error pattern.
    function automatic logic [31:0] resp_data(
        input logic        we,
        input logic        err,
        input logic [31:0] rdata
    );
        if (err) return ERR_RDATA;
        if (we)  return 32'h0;
        return rdata;
    endfunction

endpackage

// File: rtl/sap_timeout_cnt.sv
// Saturating wait counter for a reg access; expired flags the last
// allowed cycle. Ports: clk_i, rst_i, clear, enable -> expired.
module sap_timeout_cnt #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] LAST = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

    logic [W-1:0] cnt;

    // Saturates instead of wrapping; the owner leaves the wait state
    // on expiry, so saturation only matters when LIMIT is 0.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (LIMIT != 0) && (cnt == LAST);

endmodule

// File: rtl/sap_obi2reg_bridge.sv
// Single-outstanding OBI to reg-interface bridge with access timeout.
// Ports: clk_i, rst_i, obi_req_i/obi_resp_o, reg_req_o/reg_rsp_i,
// err_o (error pulse with rvalid), busy_o (not idle).
module sap_obi2reg_bridge
    import sap_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  obi_req_t  obi_req_i,
    output obi_resp_t obi_resp_o,
    output reg_req_t  reg_req_o,
    input  reg_rsp_t  reg_rsp_i,
    output logic      err_o,
    output logic      busy_o
);

    bridge_state_e state_q, state_d;

    logic [31:0] addr_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic gnt;
    logic expired;
    logic in_access;

    assign in_access = (state_q == ACCESS);

    sap_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (!in_access),
        .enable  (in_access && !reg_rsp_i.ready),
        .expired (expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt) begin
                addr_q  <= obi_req_i.addr;
                we_q    <= obi_req_i.we;
                be_q    <= obi_req_i.be;
                wdata_q <= obi_req_i.wdata;
            end
            // Ready takes priority over a same-cycle expiry.
            if (in_access) begin
                if (reg_rsp_i.ready) begin
                    rdata_q <= resp_data(we_q, reg_rsp_i.error,
                                         reg_rsp_i.rdata);
                    err_q   <= reg_rsp_i.error;
                end else if (expired) begin
                    rdata_q <= ERR_RDATA;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Never grant while reset is applied: the capture
                // would be discarded by the reset branch.
                gnt = obi_req_i.req && !rst_i;
                if (gnt) state_d = ACCESS;
            end
            ACCESS: begin
                if (reg_rsp_i.ready || expired) state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        obi_resp_o.gnt    = gnt;
        obi_resp_o.rvalid = (state_q == RESP);
        obi_resp_o.rdata  = (state_q == RESP) ? rdata_q : '0;

        reg_req_o.addr    = addr_q;
        reg_req_o.write   = we_q;
        reg_req_o.wdata   = wdata_q;
        reg_req_o.wstrb   = be_q;
        reg_req_o.valid   = in_access;

        err_o             = (state_q == RESP) && err_q;
        busy_o            = (state_q != IDLE);
    end

endmodule
